// File: rtl/sdf_np_acc_pick_pkg.sv
// Shared constants and width helpers for the accumulate-and-pick actor.
// Width helpers are constant functions so parameter derivations stay in one place.
package sdf_acc_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic int tag_width(input int ch);
        return (clog2(ch) < 1) ? 1 : clog2(ch);
    endfunction

    function automatic int payload_width(input int width, input int ch);
        return width - tag_width(ch);
    endfunction

    function automatic int count_width(input int acc_len);
        return (clog2(acc_len) < 1) ? 1 : clog2(acc_len);
    endfunction

endpackage

// File: rtl/sdf_np_acc_pick_if.sv
// Input FIFO bank and output FIFO handshake of the accumulate-and-pick actor.
interface sdf_np_acc_pick_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 2
);
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_empty;
    logic [CH-1:0]       in_read;
    logic                full;
    logic                wr;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;

    modport master (
        output in_data, in_empty, full,
        input  in_read, wr, out_data, out_last
    );

    modport slave (
        input  in_data, in_empty, full,
        output in_read, wr, out_data, out_last
    );
endinterface

// File: rtl/sdf_np_acc_pick_arb.sv
// Combinational channel arbiter: fixed priority (highest index) or round-robin
// starting one past the last served channel.
module sdf_rr_arbiter
    import sdf_acc_pkg::*;
#(
    parameter int CH    = 2,
    parameter int TAG_W = 1,
    parameter int MODE  = ARB_FIXED
) (
    input  logic [CH-1:0]    i_req,
    input  logic [TAG_W-1:0] i_ptr,
    output logic [CH-1:0]    o_gnt,
    output logic [TAG_W-1:0] o_idx,
    output logic             o_any
);

    logic [TAG_W-1:0] w_idx;
    logic             w_found;

    // Select the winning channel index
    always_comb begin : p_pick
        int pos;
        pos     = 0;
        w_idx   = '0;
        w_found = 1'b0;
        if (MODE == ARB_FIXED) begin
            for (int k = 0; k < CH; k++) begin
                if (i_req[k]) begin
                    w_idx   = TAG_W'(k);
                    w_found = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end
        end else begin
            for (int off = 1; off <= CH; off++) begin
                pos = (int'(i_ptr) + off) % CH;
                if (!w_found && i_req[pos]) begin
                    w_idx   = TAG_W'(pos);
                    w_found = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Expand the winning index into a one-hot grant
    always_comb begin
        o_gnt = '0;
        for (int k = 0; k < CH; k++) begin
            if (w_found && (w_idx == TAG_W'(k))) begin
                o_gnt[k] = 1'b1;
            end else begin
                o_gnt[k] = 1'b0;
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule

// File: rtl/sdf_np_acc_pick.sv
// N-channel accumulate-and-pick actor: one granted token per cycle is summed into its
// channel's window and the tagged running or final sum is written to a shared FIFO.
module sdf_np_acc_pick
    import sdf_acc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CH           = 2,
    parameter int ACC_LEN      = 4,
    parameter int RR           = 0,
    parameter int EMIT_PARTIAL = 1
) (
    input logic              ck,
    input logic              rst,
    input logic              clr,
    sdf_np_acc_pick_if.slave bus
);

    localparam int TAG_W = tag_width(CH);
    localparam int PW    = payload_width(WIDTH, CH);
    localparam int CNT_W = count_width(ACC_LEN);

    logic [CH-1:0]            w_elig;
    logic [CH-1:0]            w_gnt;
    logic [TAG_W-1:0]         w_idx;
    logic                     w_any;
    logic [CH-1:0][PW-1:0]    w_acc;
    logic [CH-1:0][CNT_W-1:0] w_cnt;
    logic [PW-1:0]            w_tok;
    logic [PW-1:0]            w_sum;
    logic                     w_close;
    logic [TAG_W-1:0]         r_rr_ptr;

    logic [CH-1:0]            w_read;
    logic                     w_wr;
    logic                     w_last;
    logic [WIDTH-1:0]         w_out;

    // A full output FIFO or a clear blocks every channel for this cycle
    always_comb begin
        if (bus.full || clr) begin
            w_elig = '0;
        end else begin
            w_elig = ~bus.in_empty;
        end
    end

    sdf_rr_arbiter #(
        .CH    (CH),
        .TAG_W (TAG_W),
        .MODE  ((RR != 0) ? ARB_RR : ARB_FIXED)
    ) u_arb (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_tok   = bus.in_data[int'(w_idx)*WIDTH +: PW];
    assign w_sum   = w_acc[w_idx] + w_tok;
    assign w_close = (w_cnt[w_idx] == CNT_W'(ACC_LEN - 1));

    // Zero-latency handshake, forced quiet while reset is asserted
    always_comb begin
        w_read = '0;
        w_wr   = 1'b0;
        w_last = 1'b0;
        w_out  = '0;
        if (!rst && w_any) begin
            w_read = w_gnt;
            w_last = w_close;
            w_wr   = (EMIT_PARTIAL != 0) || w_close;
            w_out  = {w_idx, w_sum};
        end else begin
            w_read = '0;
        end
    end

    assign bus.in_read  = w_read;
    assign bus.wr       = w_wr;
    assign bus.out_data = w_out;
    assign bus.out_last = w_last;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [PW-1:0]    r_acc;
        logic [CNT_W-1:0] r_cnt;
        logic             w_hit;

        assign w_hit = w_any && (w_idx == TAG_W'(k));

        // Window sum and position; untouched unless this channel is granted
        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_hit) begin
                if (w_close) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_acc <= r_acc;
                r_cnt <= r_cnt;
            end
        end

        assign w_acc[k] = r_acc;
        assign w_cnt[k] = r_cnt;
    end

    // Remember the last served channel; resets so channel 0 is served first
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= TAG_W'(CH - 1);
        end else if ((RR == ARB_RR) && w_any) begin
            r_rr_ptr <= w_idx;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

endmodule

// File: tb/tb_sdf_np_acc_pick.sv
// Bench for sdf_np_acc_pick: three instances (fixed priority, round-robin, final-only)
// checked against a per-window arithmetic model through directed and random steps.
module tb_sdf_np_acc_pick;

    localparam int NCH  = 2;
    localparam int ALEN = 4;

    logic ck;
    logic rst;
    logic clr;

    logic [15:0] in_data  [3];
    logic [1:0]  in_empty [3];
    logic        full     [3];
    logic [1:0]  rd       [3];
    logic        wr       [3];
    logic [7:0]  od       [3];
    logic        ol       [3];

    int checks = 0;
    int errors = 0;

    int m_acc    [3][NCH];
    int m_cnt    [3][NCH];
    int m_last_g [3];

    sdf_np_acc_pick_if #(.WIDTH(8), .CH(2)) bus0 ();
    sdf_np_acc_pick_if #(.WIDTH(8), .CH(2)) bus1 ();
    sdf_np_acc_pick_if #(.WIDTH(8), .CH(2)) bus2 ();

    assign bus0.in_data  = in_data[0];
    assign bus0.in_empty = in_empty[0];
    assign bus0.full     = full[0];
    assign bus1.in_data  = in_data[1];
    assign bus1.in_empty = in_empty[1];
    assign bus1.full     = full[1];
    assign bus2.in_data  = in_data[2];
    assign bus2.in_empty = in_empty[2];
    assign bus2.full     = full[2];

    assign rd[0] = bus0.in_read;
    assign wr[0] = bus0.wr;
    assign od[0] = bus0.out_data;
    assign ol[0] = bus0.out_last;
    assign rd[1] = bus1.in_read;
    assign wr[1] = bus1.wr;
    assign od[1] = bus1.out_data;
    assign ol[1] = bus1.out_last;
    assign rd[2] = bus2.in_read;
    assign wr[2] = bus2.wr;
    assign od[2] = bus2.out_data;
    assign ol[2] = bus2.out_last;

    sdf_np_acc_pick #(.WIDTH(8), .CH(2), .ACC_LEN(4), .RR(0), .EMIT_PARTIAL(1)) u_fix (
        .ck(ck), .rst(rst), .clr(clr), .bus(bus0)
    );
    sdf_np_acc_pick #(.WIDTH(8), .CH(2), .ACC_LEN(4), .RR(1), .EMIT_PARTIAL(1)) u_rr (
        .ck(ck), .rst(rst), .clr(clr), .bus(bus1)
    );
    sdf_np_acc_pick #(.WIDTH(8), .CH(2), .ACC_LEN(4), .RR(0), .EMIT_PARTIAL(0)) u_fin (
        .ck(ck), .rst(rst), .clr(clr), .bus(bus2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic bit rr_of(input int d);
        return (d == 1);
    endfunction

    function automatic bit ep_of(input int d);
        return (d != 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_acc[d][ch] = 0;
                m_cnt[d][ch] = 0;
            end
            m_last_g[d] = NCH - 1;
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            in_empty[i] = 2'b11;
            in_data[i]  = 16'h0000;
            full[i]     = 1'b0;
        end
    endtask

    // One cycle on instance d: drive at posedge+1, check at negedge, advance model.
    task automatic step(input int d, input logic [1:0] emp, input logic [7:0] d0,
                        input logic [7:0] d1, input logic fl, input logic cl);
        logic [1:0] elig;
        int g, tok, sum;
        bit close;
        idle_all();
        in_empty[d] = emp;
        in_data[d]  = {d1, d0};
        full[d]     = fl;
        clr         = cl;
        #4;
        elig = (fl || cl) ? 2'b00 : ~emp;
        g = -1;
        if (rr_of(d)) begin
            for (int off = 1; off <= NCH; off++) begin
                int ch;
                ch = (m_last_g[d] + off) % NCH;
                if (g < 0 && elig[ch]) g = ch;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (elig[ch]) g = ch;
            end
        end
        if (g < 0) begin
            chk("idle_read", rd[d], 0);
            chk("idle_wr", wr[d], 0);
            chk("idle_last", ol[d], 0);
            chk("idle_data", od[d], 0);
        end else begin
            tok   = int'((g == 0) ? d0 : d1) % 128;
            sum   = (m_acc[d][g] + tok) % 128;
            close = (m_cnt[d][g] == ALEN - 1);
            chk("read", rd[d], 32'(1 << g));
            chk("wr", wr[d], 32'(ep_of(d) || close));
            chk("last", ol[d], 32'(close));
            if (ep_of(d) || close) chk("data", od[d], 32'(g * 128 + sum));
        end
        for (int i = 0; i < 3; i++) begin
            if (i != d) chk("other_wr", wr[i], 0);
        end
        if (cl) begin
            for (int i = 0; i < 3; i++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    m_acc[i][ch] = 0;
                    m_cnt[i][ch] = 0;
                end
            end
        end else if (g >= 0) begin
            if (close) begin
                m_acc[d][g] = 0;
                m_cnt[d][g] = 0;
            end else begin
                m_acc[d][g] = sum;
                m_cnt[d][g] = m_cnt[d][g] + 1;
            end
            if (rr_of(d)) m_last_g[d] = g;
        end
        @(posedge ck);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_empty[i] = 2'b00;
            in_data[i]  = 16'hFFFF;
            full[i]     = 1'b0;
        end
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_read", rd[i], 0);
            chk("rst_wr", wr[i], 0);
            chk("rst_data", od[i], 0);
            chk("rst_last", ol[i], 0);
        end
        idle_all();
        @(negedge ck);
        rst = 1'b0;
        @(posedge ck);
        #1;

        // ch0 window 1..4 then start of the next one
        for (int k = 1; k <= 5; k++) step(0, 2'b10, 8'(k), 8'h00, 1'b0, 1'b0);
        // ch1 payload wrap
        step(0, 2'b01, 8'h00, 8'h7F, 1'b0, 1'b0);
        step(0, 2'b01, 8'h00, 8'h02, 1'b0, 1'b0);
        step(0, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1);
        // fixed priority: ch1 always wins
        for (int k = 0; k < 4; k++) step(0, 2'b00, 8'h01, 8'h01, 1'b0, 1'b0);
        // round-robin alternates channels
        for (int k = 0; k < 4; k++) step(1, 2'b00, 8'h01, 8'h02, 1'b0, 1'b0);
        // back-pressure freezes a half-filled window
        step(0, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1);
        step(0, 2'b10, 8'h01, 8'h00, 1'b0, 1'b0);
        step(0, 2'b10, 8'h02, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(0, 2'b10, 8'h09, 8'h00, 1'b1, 1'b0);
        step(0, 2'b10, 8'h04, 8'h00, 1'b0, 1'b0);
        step(0, 2'b10, 8'h05, 8'h00, 1'b0, 1'b0);
        // asynchronous reset mid-window
        step(0, 2'b10, 8'h01, 8'h00, 1'b0, 1'b0);
        step(0, 2'b10, 8'h02, 8'h00, 1'b0, 1'b0);
        in_empty[0] = 2'b10;
        in_data[0]  = 16'h0007;
        rst = 1'b1;
        #1;
        chk("rstp_read", rd[0], 0);
        chk("rstp_wr", wr[0], 0);
        chk("rstp_data", od[0], 0);
        chk("rstp_last", ol[0], 0);
        idle_all();
        rst = 1'b0;
        model_reset();
        @(posedge ck);
        #1;
        step(0, 2'b10, 8'h07, 8'h00, 1'b0, 1'b0);
        // synchronous clear beats a pending token
        step(0, 2'b10, 8'h02, 8'h00, 1'b0, 1'b0);
        step(0, 2'b10, 8'h07, 8'h00, 1'b0, 1'b1);
        step(0, 2'b10, 8'h07, 8'h00, 1'b0, 1'b0);
        // final-only emission
        step(2, 2'b11, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) step(2, 2'b10, 8'(k), 8'h00, 1'b0, 1'b0);

        // randomized traffic on all three instances
        for (int n = 0; n < 400; n++) begin
            step(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
